home_scorer: RTL

Parametrised successor to the home-row point detector in the Frogger datapath. It sits between the lane/board logic and the score display. It samples the frog's position in the final row when an up-move pulse arrives and maps that column to one of SLOTS home slots. It then issues a registered one-cycle point pulse, keeps per-slot occupancy, counts the score, and signals level completion when every slot is filled.

---
 rtl/home_scorer.sv | 114 +++++++++++
 1 files changed

// File: rtl/home_scorer.sv
// home_scorer: home-row point detector for the Frogger datapath.
// On an up-move with the frog in the final row, the lowest occupied column
// is mapped to one of SLOTS home slots. A free slot gives a point pulse and
// bumps the (saturating) score. When the slot fill completes the row, a
// level_done pulse follows and the slots clear. A hit on an occupied slot
// pulses death only when HOME_DEATH_EN is defined; otherwise it is ignored.
//
// Build option: HOME_DEATH_EN (undefined by default) builds the DIED path.
//
// Ports:
//   clk          system clock, rising edge
//   reset        async active-low reset
//   U            up-move pulse
//   finalRow     frog bitmap of the row below home (bit i = column i)
//   new_game     synchronous clear of score and slots
//   point        one-cycle pulse, frog entered a free slot
//   level_done   one-cycle pulse, last free slot filled
//   death        one-cycle pulse, frog entered an occupied slot
//   slot_filled  per-slot occupancy
//   score        saturating point count
module home_scorer #(
  parameter int COLS    = 16,
  parameter int SLOTS   = 4,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               U,
  input  logic [COLS-1:0]    finalRow,
  input  logic               new_game,
  output logic               point,
  output logic               level_done,
  output logic               death,
  output logic [SLOTS-1:0]   slot_filled,
  output logic [SCORE_W-1:0] score
);

  localparam int SPAN = COLS / SLOTS;

  typedef enum logic [1:0] {IDLE, SCORED, LEVEL, DIED} state_t;
  state_t state;

  logic [COLS-1:0]  lowest;
  logic [SLOTS-1:0] slot_sel;
  logic             hit;
  logic             slot_free;

  // x & -x isolates the lowest set bit, so a frog spanning columns
  // resolves to its leftmost (lowest-index) column.
  assign lowest = finalRow & (~finalRow + COLS'(1));

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    assign slot_sel[s] = |lowest[s*SPAN +: SPAN];
  end

  assign hit       = U & (|finalRow);
  assign slot_free = ~|(slot_sel & slot_filled);

  // Pulses are registered together with the state they belong to, so each
  // output is high exactly while the FSM sits in the matching state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      point       <= 1'b0;
      level_done  <= 1'b0;
      death       <= 1'b0;
      slot_filled <= '0;
      score       <= '0;
    end else begin
      point      <= 1'b0;
      level_done <= 1'b0;
      death      <= 1'b0;
      if (new_game) begin
        state       <= IDLE;
        slot_filled <= '0;
        score       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (hit) begin
              if (slot_free) begin
                state       <= SCORED;
                point       <= 1'b1;
                slot_filled <= slot_filled | slot_sel;
                if (score != '1) score <= score + SCORE_W'(1);
              end
`ifdef HOME_DEATH_EN
              else begin
                state <= DIED;
                death <= 1'b1;
              end
`endif
            end
          end
          SCORED: begin
            // slot_filled already includes the slot taken on entry.
            if (&slot_filled) begin
              state      <= LEVEL;
              level_done <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          LEVEL: begin
            state       <= IDLE;
            slot_filled <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
